// File: rtl/score_bcd_combo.sv
// Piano-tiles score engine: combo/multiplier tracking, saturating BCD score and a persistent high score.
// Optional SCORE_HEX_EN macro adds registered active-low 7-segment decoders on seg.
module score_bcd_combo #(
  parameter int DIGITS     = 4,
  parameter int COMBO_STEP = 8,
  parameter int MAX_MULT   = 4,
  parameter int PEND_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  game_over,
  input  logic                  beat_tick,
  input  logic                  hit,
  input  logic                  miss,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7:0]            combo,
  output logic [3:0]            mult,
  output logic                  running,
  output logic                  busy,
  output logic                  saturated,
  output logic                  new_high,
  output logic [7*DIGITS-1:0]   seg
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OVER} state_t;

  localparam int SUM_W = PEND_W + 5;
  localparam logic [SUM_W-1:0] PEND_MAX = {5'd0, {PEND_W{1'b1}}};

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   score_q, score_d, high_q, high_d;
  logic [4*DIGITS-1:0]   score_inc, all_nines;
  logic [7:0]            combo_q, combo_d;
  logic [PEND_W-1:0]     pend_q, pend_d;
  logic                  new_high_q, new_high_d;
  logic [7:0]            level;
  logic [3:0]            mult_w;
  logic                  hit_ev, miss_ev, pend_nz, score_full, carry;
  logic [SUM_W-1:0]      pend_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: if (start)     state_d = RUN;
      RUN:        if (game_over) state_d = DRAIN;
      DRAIN:      if (!pend_nz)  state_d = OVER;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    running   = (state_q == RUN);
    busy      = pend_nz;
    saturated = score_full;
    new_high  = new_high_q;
    score_bcd = score_q;
    high_bcd  = high_q;
    combo     = combo_q;
    mult      = mult_w;
  end

  always_comb begin
    level = 8'(combo_q / COMBO_STEP);
    if (level >= 8'(MAX_MULT - 1)) mult_w = 4'(MAX_MULT);
    else                           mult_w = level[3:0] + 4'd1;
  end

  // A beat with neither hit nor miss counts as a miss, and miss wins over hit.
  always_comb begin
    hit_ev     = (state_q == RUN) && beat_tick && hit && !miss;
    miss_ev    = (state_q == RUN) && beat_tick && !(hit && !miss);
    pend_nz    = (pend_q != '0);
    all_nines  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) all_nines[4*i +: 4] = 4'd9;
    score_full = (score_q == all_nines);
  end

  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d    = score_q;
    combo_d    = combo_q;
    high_d     = high_q;
    new_high_d = 1'b0;
    pend_sum   = SUM_W'(pend_q) + (hit_ev ? SUM_W'(mult_w) : '0) - SUM_W'(pend_nz);
    pend_d     = (pend_sum > PEND_MAX) ? '1 : pend_sum[PEND_W-1:0];
    if (pend_nz && !score_full) score_d = score_inc;
    if (hit_ev && combo_q != 8'hFF) combo_d = combo_q + 8'd1;
    if (miss_ev) combo_d = '0;
    // Score is final on the DRAIN->OVER transition, so the compare happens there.
    if (state_q == DRAIN && !pend_nz && score_q > high_q) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
    if ((state_q == IDLE || state_q == OVER) && start) begin
      score_d = '0;
      combo_d = '0;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q    <= '0;
      high_q     <= '0;
      combo_q    <= '0;
      pend_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      combo_q    <= combo_d;
      pend_q     <= pend_d;
      new_high_q <= new_high_d;
    end
  end

`ifdef SCORE_HEX_EN
  logic [7*DIGITS-1:0] seg_q, seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'd0:    hex7 = 7'b1000000;
      4'd1:    hex7 = 7'b1111001;
      4'd2:    hex7 = 7'b0100100;
      4'd3:    hex7 = 7'b0110000;
      4'd4:    hex7 = 7'b0011001;
      4'd5:    hex7 = 7'b0010010;
      4'd6:    hex7 = 7'b0000010;
      4'd7:    hex7 = 7'b1111000;
      4'd8:    hex7 = 7'b0000000;
      4'd9:    hex7 = 7'b0010000;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    seg_d = '1;
    for (int unsigned i = 0; i < DIGITS; i++) seg_d[7*i +: 7] = hex7(score_q[4*i +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= '1;
    else       seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = '1;
`endif

endmodule

// File: tb/tb_score_bcd_combo.sv
// Scoreboard bench for score_bcd_combo: stimulus pushes expected snapshots, a negedge monitor pops and compares.
module tb_score_bcd_combo;

  logic        clk = 1'b0;
  logic        reset, start, game_over, beat_tick, hit, miss;
  logic [15:0] score_bcd, high_bcd;
  logic [7:0]  combo;
  logic [3:0]  mult;
  logic        running, busy, saturated, new_high;
  logic [27:0] seg;

  score_bcd_combo #(
    .DIGITS(4), .COMBO_STEP(8), .MAX_MULT(4), .PEND_W(6)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .game_over(game_over),
    .beat_tick(beat_tick), .hit(hit), .miss(miss),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .combo(combo), .mult(mult),
    .running(running), .busy(busy), .saturated(saturated), .new_high(new_high),
    .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] score, high;
    logic [7:0]  combo;
    logic [3:0]  mult;
    logic        sat, busy, run, nh;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] nh_q[$];
  exp_t        mon_e;
  logic [15:0] nh_exp;
  int          n_cmp = 0, n_err = 0, nh_seen = 0;
  int          m_score = 0, m_combo = 0;
  bit          m_run = 0;

  function automatic int m_mult();
    return 1 + (((m_combo / 8) < 3) ? (m_combo / 8) : 3);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [15:0] sc, input logic [15:0] hi,
                      input logic [7:0] cb, input logic [3:0] ml, input logic sa,
                      input logic bz, input logic rn, input logic nh);
    exp_t e;
    e.name = nm; e.score = sc; e.high = hi; e.combo = cb; e.mult = ml;
    e.sat = sa; e.busy = bz; e.run = rn; e.nh = nh;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic h, input logic m);
    beat_tick = 1'b1; hit = h; miss = m;
    if (m_run) begin
      if (h && !m) begin
        m_score = (m_score + m_mult() > 9999) ? 9999 : m_score + m_mult();
        if (m_combo < 255) m_combo++;
      end else begin
        m_combo = 0;
      end
    end
    tick();
    beat_tick = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      tick();
    end
    n_cmp++; n_err++;
    $display("FAIL %s drain_timeout: busy still %0b after 200 cycles, required 0", nm, busy);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0; m_combo = 0; m_run = 1;
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, required %0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp(mon_e.name, "score_bcd", 32'(score_bcd), 32'(mon_e.score));
      cmp(mon_e.name, "high_bcd",  32'(high_bcd),  32'(mon_e.high));
      cmp(mon_e.name, "combo",     32'(combo),     32'(mon_e.combo));
      cmp(mon_e.name, "mult",      32'(mult),      32'(mon_e.mult));
      cmp(mon_e.name, "saturated", 32'(saturated), 32'(mon_e.sat));
      cmp(mon_e.name, "busy",      32'(busy),      32'(mon_e.busy));
      cmp(mon_e.name, "running",   32'(running),   32'(mon_e.run));
      cmp(mon_e.name, "new_high",  32'(new_high),  32'(mon_e.nh));
`ifndef SCORE_HEX_EN
      cmp(mon_e.name, "seg",       32'(seg),       32'h0FFF_FFFF);
`endif
    end
    if (new_high) begin
      nh_seen++;
      n_cmp++;
      if (nh_q.size() == 0) begin
        n_err++;
        $display("FAIL new_high_pulse: got unexpected pulse with high_bcd %h, required no pulse", high_bcd);
      end else begin
        nh_exp = nh_q.pop_front();
        if (high_bcd !== nh_exp) begin
          n_err++;
          $display("FAIL new_high_value: got high_bcd %h, required %h", high_bcd, nh_exp);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; game_over = 1'b0;
    beat_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    tick(); tick();
    push("reset", 16'h0000, 16'h0000, 8'd0, 4'd1, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    beat(1, 0);
    tick();
    push("idle_beat", 16'h0000, 16'h0000, 8'd0, 4'd1, 0, 0, 0, 0);

    start_game();
    repeat (3) beat(1, 0);
    wait_drain("three_hits");
    push("three_hits", 16'h0003, 16'h0000, 8'd3, 4'd1, 0, 0, 1, 0);
    repeat (6) beat(1, 0);
    wait_drain("ninth_hit");
    push("ninth_hit", 16'h0010, 16'h0000, 8'd9, 4'd2, 0, 0, 1, 0);
    beat(0, 1);
    wait_drain("miss");
    push("miss", 16'h0010, 16'h0000, 8'd0, 4'd1, 0, 0, 1, 0);
    beat(1, 0); beat(1, 1);
    wait_drain("hit_and_miss");
    push("hit_and_miss", 16'h0011, 16'h0000, 8'd0, 4'd1, 0, 0, 1, 0);
    beat(1, 0); beat(0, 0);
    wait_drain("no_key");
    push("no_key", 16'h0012, 16'h0000, 8'd0, 4'd1, 0, 0, 1, 0);

    while (m_score < 999) begin
      if (999 - m_score < m_mult()) beat(0, 1);
      else                          beat(1, 0);
      wait_drain("to_0999");
    end
    push("preset_0999", 16'h0999, 16'h0000, 8'(m_combo), 4'(m_mult()), 0, 0, 1, 0);
    beat(0, 1); beat(1, 0);
    wait_drain("ripple_1000");
    push("ripple_1000", 16'h1000, 16'h0000, 8'd1, 4'd1, 0, 0, 1, 0);
    while (m_score < 9999) begin
      beat(1, 0);
      wait_drain("to_9999");
    end
    push("reach_9999", 16'h9999, 16'h0000, 8'd255, 4'd4, 1, 0, 1, 0);
    repeat (3) beat(1, 0);
    wait_drain("sat_hold");
    push("sat_hold", 16'h9999, 16'h0000, 8'd255, 4'd4, 1, 0, 1, 0);

    // One mult-4 hit, one drain cycle, then game_over sees pending == 3.
    beat(1, 0);
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    m_run = 0;
    push("drain_1", 16'h9999, 16'h0000, 8'd255, 4'd4, 1, 1, 0, 0);
    tick();
    push("drain_2", 16'h9999, 16'h0000, 8'd255, 4'd4, 1, 1, 0, 0);
    tick();
    push("drain_3", 16'h9999, 16'h0000, 8'd255, 4'd4, 1, 0, 0, 0);
    nh_q.push_back(16'h9999);
    tick();
    push("over_pulse", 16'h9999, 16'h9999, 8'd255, 4'd4, 1, 0, 0, 1);
    tick();
    push("over_after", 16'h9999, 16'h9999, 8'd255, 4'd4, 1, 0, 0, 0);
    beat(1, 0);
    tick();
    push("over_beat", 16'h9999, 16'h9999, 8'd255, 4'd4, 1, 0, 0, 0);

    start_game();
    push("restart", 16'h0000, 16'h9999, 8'd0, 4'd1, 0, 0, 1, 0);
    repeat (5) beat(1, 0);
    wait_drain("game2");
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    m_run = 0;
    repeat (4) tick();
    push("game2_over", 16'h0005, 16'h9999, 8'd5, 4'd1, 0, 0, 0, 0);

    start_game();
    repeat (10) beat(1, 0);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    m_run = 0;
    push("drain_game3", 16'h0010, 16'h9999, 8'd10, 4'd2, 0, 1, 0, 0);
    tick();
    #1;
    reset = 1'b1;
    push("reset_in_drain", 16'h0000, 16'h0000, 8'd0, 4'd1, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    n_cmp++;
    if (nh_seen != 1 || nh_q.size() != 0) begin
      n_err++;
      $display("FAIL new_high_count: got %0d pulses (%0d still expected), required 1", nh_seen, nh_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_bcd_combo.md
Name: score_bcd_combo

Overview:
Parametrised BCD score engine for the piano-tiles game. Runs on the system clock and takes one-cycle beat strobes carrying hit/miss results. Maintains a streak (combo) counter with a score multiplier, a saturating multi-digit BCD score, and a high-score register that persists across games. Sits between the key-judging logic and the HEX display drivers.

Parameters:
DIGITS, 4, number of BCD digits in score and high score (2..6)
COMBO_STEP, 8, consecutive hits needed per multiplier level (>=1)
MAX_MULT, 4, maximum multiplier (1..9)
PEND_W, 6, width of pending-points counter

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high; clears everything including high score
start  in  1  level/strobe; in IDLE or OVER begins a new game
game_over  in  1  strobe; ends the running game
beat_tick  in  1  one-cycle strobe per beat judgement, synchronous to clk
hit  in  1  qualified by beat_tick: correct key pressed
miss  in  1  qualified by beat_tick: wrong or no key
score_bcd  out  4*DIGITS  current score, digit 0 = LSBs
high_bcd  out  4*DIGITS  best score since reset
combo  out  8  current streak, saturates at 255
mult  out  4  current multiplier (1..MAX_MULT)
running  out  1  high in RUN
busy  out  1  high while pending points are nonzero
saturated  out  1  high when score is all 9s
new_high  out  1  one-cycle pulse when high_bcd is updated
seg  out  7*DIGITS  active-low 7-segment patterns for score_bcd (see Optional Feature)

Behaviour:
- Reset (async): score_bcd=0, high_bcd=0, combo=0, mult=1, pending=0, state=IDLE; running, busy, saturated and new_high are 0.
- States: IDLE, RUN, DRAIN, OVER.
- IDLE/OVER + start: clear score, combo, pending and saturated; mult=1; go to RUN next cycle. start is ignored in RUN and DRAIN.
- mult = 1 + min(combo / COMBO_STEP, MAX_MULT-1), computed from registered combo.
- RUN, beat_tick & hit & !miss: pending += mult (value before the increment), saturating at 2^PEND_W-1; combo += 1 (saturates at 255).
- RUN, beat_tick & miss: combo=0 and no points; miss wins if hit is also set. beat_tick with neither input set is treated as a miss.
- beat_tick outside RUN is ignored.
- Score adder: while pending != 0, score_bcd increments by 1 BCD unit per clk with ripple carry across all digits, and pending decrements. A beat add and a drain decrement in the same cycle combine: pending += mult-1.
- busy = (pending != 0).
- Saturation: if score is all 9s, further increments are discarded (pending still drains) and saturated=1.
- RUN + game_over: go to DRAIN. Further beats are ignored. DRAIN -> OVER when pending == 0.
- On entering OVER: if score_bcd > high_bcd (BCD magnitude compare), load high_bcd and pulse new_high for 1 cycle.
- Reset mid-drain: all state clears immediately; no high-score update.

Optional Feature:
SCORE_HEX_EN
- Defined: seg carries DIGITS registered hex-to-7-seg decoders (active-low, 0-9 plus blank for invalid codes), updated 1 clk after score_bcd.
- Undefined: seg is tied to all ones (blank), and no decoder logic is generated.

Test Plan:
- reset, start, 3 beats with hit -> score_bcd=0003 after drain, combo=3, mult=1, busy low.
- 8 hits then 1 hit (COMBO_STEP=8) -> the 9th hit adds 2, so score=0010 and mult=2. Then a miss -> combo=0, mult=1, score unchanged.
- Score preset near 0999 via hits, then 1 hit -> 1000 with correct ripple carry. Continue to 9999 -> saturated=1; further hits leave 9999 and pending drains to 0.
- game_over while pending=3 -> state stays in DRAIN for 3 cycles, then OVER. high_bcd takes the score and new_high pulses exactly once. A second game with a lower score -> high_bcd unchanged, no pulse.
- beat_tick with hit and miss both high -> treated as a miss. Beats in IDLE/OVER -> no change.
- Assert reset during DRAIN -> all outputs return to reset values asynchronously, and high_bcd=0.
